// File: rtl/sub_serial.sv
// Bit-serial W-bit subtractor: a - b - b_in, LSB first, one full-subtractor step per clock.
// Optional signed overflow output enabled by defining SUB_SERIAL_OVF_EN.
module sub_serial #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         b_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         b_out
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  a_reg, b_reg, res_reg, diff_reg;
    logic [CW-1:0] cnt_reg;
    logic          br_reg, bout_reg;
    logic          a0, b0, d, br_next, last;

    assign a0      = a_reg[0];
    assign b0      = b_reg[0];
    assign d       = a0 ^ b0 ^ br_reg;
    assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br_reg);
    assign last    = (cnt_reg == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == RUN);
        done = (state_reg == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            res_reg  <= '0;
            diff_reg <= '0;
            cnt_reg  <= '0;
            br_reg   <= 1'b0;
            bout_reg <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            a_reg   <= a;
            b_reg   <= b;
            br_reg  <= b_in;
            cnt_reg <= '0;
        end else if (state_reg == RUN) begin
            a_reg   <= {1'b0, a_reg[W-1:1]};
            b_reg   <= {1'b0, b_reg[W-1:1]};
            res_reg <= {d, res_reg[W-1:1]};
            br_reg  <= br_next;
            if (last) begin
                // final bit goes straight into the published result, not via res_reg
                diff_reg <= {d, res_reg[W-1:1]};
                bout_reg <= br_next;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign diff  = diff_reg;
    assign b_out = bout_reg;

`ifdef SUB_SERIAL_OVF_EN
    logic am_reg, bm_reg, ovf_reg;

    // operand sign bits are shifted out during RUN, so keep copies from load time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            am_reg  <= 1'b0;
            bm_reg  <= 1'b0;
            ovf_reg <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            am_reg <= a[W-1];
            bm_reg <= b[W-1];
        end else if (state_reg == RUN && last) begin
            ovf_reg <= (am_reg != bm_reg) && (d != am_reg);
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule
